// File: rtl/uart_pkt_tx_if.sv
// Source-side bundle of uart_pkt_tx: message FIFO heads in, pops and tx line out.
`timescale 1ns/1ps
interface uart_pkt_tx_if #(
    parameter int N_SRC = 8
);
    logic [N_SRC-1:0]   have_msg;
    logic [8*N_SRC-1:0] msg_len;
    logic [8*N_SRC-1:0] rd_data;
    logic [N_SRC-1:0]   rd_en;
    logic               tx;
    logic               busy;
    logic               sent;

    modport master (
        output have_msg, msg_len, rd_data,
        input  rd_en, tx, busy, sent
    );

    modport slave (
        input  have_msg, msg_len, rd_data,
        output rd_en, tx, busy, sent
    );
endinterface

// File: rtl/uart_pkt_tx.sv
// Round-robin packet framer + UART serializer (PREFIX, addr, len, payload, crc).
// Define UART_PKT_TX_CRC_EN for a CRC-8 (poly 0x07) trailer, else 8'hFF.
`timescale 1ns/1ps
module uart_pkt_tx #(
    parameter int         CLK_FREQ  = 48000000,
    parameter int         BAUD      = 115200,
    parameter int         N_SRC     = 8,
    parameter logic [7:0] ADDR_BASE = 8'h10,
    parameter logic [7:0] PREFIX    = 8'hDD
) (
    input  logic         clk,
    input  logic         rst,
    uart_pkt_tx_if.slave bus
);
    localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int DW  = $clog2(DIV + 1);
    localparam int IW  = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_PREFIX,
        ST_ADDR,
        ST_LEN,
        ST_PAYLOAD,
        ST_CRC
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [3:0]    bit_q, bit_d;
    logic [DW-1:0] div_q, div_d;
    logic          act_q, act_d;

    logic             win_found;
    logic [IW-1:0]    win_idx;
    logic             tick;
    logic             byte_done;
    logic             load;
    logic [7:0]       load_byte;
    logic [7:0]       rd_byte;
    logic [7:0]       crc_byte;
    logic [N_SRC-1:0] rd_en_c;
    logic             sent_c;

    // First pending source strictly after rr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            if (!win_found && bus.have_msg[(int'(rr_q) + k) % N_SRC]) begin
                win_found = 1'b1;
                win_idx   = IW'((int'(rr_q) + k) % N_SRC);
            end
        end
    end

    assign tick      = act_q && (div_q == DW'(DIV - 1));
    assign byte_done = tick && (bit_q == 4'd9);
    assign rd_byte   = bus.rd_data[8*int'(idx_q) +: 8];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rr_d      = rr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        div_d     = div_q;
        act_d     = act_q;
        load      = 1'b0;
        load_byte = 8'h00;
        rd_en_c   = '0;
        sent_c    = 1'b0;

        if (act_q) begin
            if (tick) begin
                div_d = '0;
                if (bit_q != 4'd9) begin
                    bit_d   = bit_q + 4'd1;
                    shift_d = {1'b1, shift_q[9:1]};
                end
            end else begin
                div_d = div_q + DW'(1);
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    idx_d   = win_idx;
                    len_d   = bus.msg_len[8*int'(win_idx) +: 8];
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                load      = 1'b1;
                load_byte = PREFIX;
                state_d   = ST_PREFIX;
            end
            ST_PREFIX: begin
                if (byte_done) begin
                    load      = 1'b1;
                    load_byte = ADDR_BASE + 8'(idx_q);
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (byte_done) begin
                    load      = 1'b1;
                    load_byte = len_q;
                    state_d   = ST_LEN;
                end
            end
            ST_LEN: begin
                if (byte_done) begin
                    load = 1'b1;
                    if (len_q == 8'd0) begin
                        load_byte = crc_byte;
                        state_d   = ST_CRC;
                    end else begin
                        load_byte      = rd_byte;
                        rd_en_c[idx_q] = 1'b1;
                        cnt_d          = 8'd0;
                        state_d        = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (byte_done) begin
                    load = 1'b1;
                    if (cnt_q == len_q - 8'd1) begin
                        load_byte = crc_byte;
                        state_d   = ST_CRC;
                    end else begin
                        load_byte      = rd_byte;
                        rd_en_c[idx_q] = 1'b1;
                        cnt_d          = cnt_q + 8'd1;
                    end
                end
            end
            ST_CRC: begin
                if (byte_done) begin
                    sent_c  = 1'b1;
                    act_d   = 1'b0;
                    rr_d    = idx_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Next byte starts the cycle after the previous stop bit: no gap.
        if (load) begin
            shift_d = {1'b1, load_byte, 1'b0};
            bit_d   = 4'd0;
            div_d   = '0;
            act_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rr_q    <= IW'(N_SRC - 1);
            len_q   <= 8'd0;
            cnt_q   <= 8'd0;
            shift_q <= '1;
            bit_q   <= 4'd0;
            div_q   <= '0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            act_q   <= act_d;
        end
    end

`ifdef UART_PKT_TX_CRC_EN
    logic [7:0] crc_q, crc_d;

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction

    // Covers ADDR, LEN and payload loads; PREFIX and the crc byte are excluded.
    always_comb begin
        crc_d = crc_q;
        if (state_q == ST_GRANT) begin
            crc_d = 8'h00;
        end else if (load && (state_d != ST_CRC)) begin
            crc_d = crc8(crc_q, load_byte);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_byte = crc_q;
`else
    assign crc_byte = 8'hFF;
`endif

    assign bus.tx    = act_q ? shift_q[0] : 1'b1;
    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.sent  = sent_c;
    assign bus.rd_en = rd_en_c;
endmodule
